// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module : noc_pkg
// Brief  : Shared flit-type encoding and arbiter state types for NoC switches.
// Rev    : 1.0
// ============================================================================
package noc_pkg;

    localparam int FLIT_TYPE_W = 2;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        FT_HEAD   = 2'b00,
        FT_BODY   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Takes the flit's top FLIT_TYPE_W bits so it works for any flit width.
    function automatic flit_type_e flit_type(input logic [FLIT_TYPE_W-1:0] type_field);
        return flit_type_e'(type_field);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational wrap-around priority arbiter starting at i_start_ptr.
// Rev    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N     = 5,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_start_ptr,
    output logic [N-1:0]     o_grant,
    output logic [PTR_W-1:0] o_grant_idx
);

    // Scan from farthest to nearest so the requester closest to the pointer wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[(int'(i_start_ptr) + k) % N]) begin
                o_grant                                 = '0;
                o_grant[(int'(i_start_ptr) + k) % N]    = 1'b1;
                o_grant_idx = PTR_W'((int'(i_start_ptr) + k) % N);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/switch_rr_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module : switch_rr_output_arbiter
// Brief  : Per-output-port wormhole arbiter + mux with registered output.
// Rev    : 1.0
// ============================================================================
module switch_rr_output_arbiter
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int N_PORTS    = 5,
    parameter int RR_MODE    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS-1:0]            in_req,
    input  logic [N_PORTS*DATA_WIDTH-1:0] in_data,
    output logic [N_PORTS-1:0]            in_ack,
    output logic                          out_req,
    output logic [DATA_WIDTH-1:0]         out_data,
    input  logic                          out_ack,
    output logic [N_PORTS-1:0]            owner,
    output logic                          proto_err
);

    localparam int                 C_PTR_W    = $clog2(N_PORTS);
    localparam logic [C_PTR_W-1:0] C_LAST_IDX = C_PTR_W'(N_PORTS - 1);

    arb_state_e              r_state, w_state_nxt;
    logic [C_PTR_W-1:0]      r_lock_idx, w_lock_idx_nxt;
    logic [C_PTR_W-1:0]      r_rr_ptr, w_rr_ptr_nxt;
    logic                    r_out_req;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_proto_err, w_err_set;

    logic [C_PTR_W-1:0]      w_start_ptr, w_arb_idx, w_sel_idx;
    logic [N_PORTS-1:0]      w_arb_grant, w_grant, w_ack, w_lock_onehot;
    logic                    w_free, w_xfer;
    logic [DATA_WIDTH-1:0]   w_sel_flit;
    flit_type_e              w_sel_type;

    function automatic logic [C_PTR_W-1:0] wrap_inc(input logic [C_PTR_W-1:0] idx);
        return (idx == C_LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    assign w_start_ptr   = (RR_MODE != 0) ? r_rr_ptr : '0;
    assign w_lock_onehot = {{(N_PORTS-1){1'b0}}, 1'b1} << r_lock_idx;

    rr_arbiter #(
        .N     (N_PORTS),
        .PTR_W (C_PTR_W)
    ) u_rr_arbiter (
        .i_req       (in_req),
        .i_start_ptr (w_start_ptr),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_arb_idx)
    );

    // A locked packet owns the port; other inputs starve until its TAIL passes.
    always_comb begin
        w_grant   = '0;
        w_sel_idx = r_lock_idx;
        if (r_state == ST_IDLE) begin
            w_grant   = w_arb_grant;
            w_sel_idx = w_arb_idx;
        end else if (in_req[r_lock_idx]) begin
            w_grant   = w_lock_onehot;
        end
    end

    assign w_free     = !r_out_req || out_ack;
    assign w_ack      = rst ? '0 : (w_grant & {N_PORTS{w_free}});
    assign w_xfer     = |w_ack;
    assign w_sel_flit = in_data[int'(w_sel_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_type = flit_type(w_sel_flit[DATA_WIDTH-1 -: FLIT_TYPE_W]);

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_idx_nxt = r_lock_idx;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_err_set      = 1'b0;
        if (w_xfer) begin
            case (r_state)
                ST_IDLE: begin
                    case (w_sel_type)
                        FT_HEAD: begin
                            w_state_nxt    = ST_LOCKED;
                            w_lock_idx_nxt = w_sel_idx;
                        end
                        FT_SINGLE: w_rr_ptr_nxt = wrap_inc(w_sel_idx);
                        default: begin
                            w_err_set    = 1'b1;
                            w_rr_ptr_nxt = wrap_inc(w_sel_idx);
                        end
                    endcase
                end
                ST_LOCKED: begin
                    case (w_sel_type)
                        FT_TAIL: begin
                            w_state_nxt  = ST_IDLE;
                            w_rr_ptr_nxt = wrap_inc(r_lock_idx);
                        end
                        FT_BODY: w_err_set = 1'b0;
                        default: w_err_set = 1'b1;
                    endcase
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_lock_idx  <= '0;
            r_rr_ptr    <= '0;
            r_out_req   <= 1'b0;
            r_out_data  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_idx <= w_lock_idx_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            if (w_xfer) begin
                r_out_req  <= 1'b1;
                r_out_data <= w_sel_flit;
            end else if (out_ack) begin
                r_out_req  <= 1'b0;
            end
            if (w_err_set) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign in_ack    = w_ack;
    assign out_req   = r_out_req;
    assign out_data  = r_out_data;
    assign owner     = (!rst && r_state == ST_LOCKED) ? w_lock_onehot : '0;
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire
